// File: rtl/fetch_queue.sv
// fetch_queue -- decoupled instruction-fetch front end.
//
// Owns the fetch PC and issues in-order requests to an instruction memory
// over a valid/ready request channel. Returned instructions are tagged with
// their PC and buffered in a DEPTH-entry FIFO that feeds decode. A redirect
// (branch/jump) flushes the FIFO, reloads the PCs and arranges for every
// response still in flight to be discarded when it arrives.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   redirect_valid, redirect_pc   redirect fetch; redirect_pc[1:0] are ignored
//   imem_req_valid/ready/addr     request channel to imem (addr = fetch PC)
//   imem_rsp_valid/data           in-order responses, one per accepted request
//   dec_valid/ready               head-of-queue handshake with decode
//   dec_instr, dec_pc, dec_pc_plus4  head entry (all zero while empty)
//   occupancy                     number of FIFO entries held
//   protocol_err                  sticky: a response arrived with nothing outstanding
//
// DEPTH must be a power of two and at least 2 so the FIFO pointers wrap
// naturally.

module fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ILEN-1:0]            imem_rsp_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [ILEN-1:0]            dec_instr,
    output logic [XLEN-1:0]            dec_pc,
    output logic [XLEN-1:0]            dec_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       protocol_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);
    // After a redirect up to DEPTH stale requests can still be in flight
    // while DEPTH fresh ones are issued, so outstanding may reach 2*DEPTH.
    localparam int CW = $clog2(2*DEPTH+1) + 1;

    // Architectural state
    logic [XLEN-1:0] fetchPc;      // address of the next request
    logic [XLEN-1:0] rspPc;        // PC that the next kept response belongs to
    logic [PW-1:0]   wrPtr;
    logic [PW-1:0]   rdPtr;
    logic [OW-1:0]   occCnt;
    logic [CW-1:0]   outstanding;  // accepted requests not yet answered
    logic [CW-1:0]   dropCnt;      // of those, how many belong to a dead path
    logic            protocolErr;

    // FIFO storage; the head is read combinationally so that an entry
    // pushed at one edge is visible to decode right after that edge.
    logic [ILEN-1:0] instrMem [DEPTH];
    logic [XLEN-1:0] pcMem    [DEPTH];

    // Handshake and bookkeeping terms
    logic [CW-1:0]   credit;
    logic            reqFire;
    logic            rspAccept;
    logic            rspOrphan;
    logic            rspDrop;
    logic            pushEn;
    logic            popEn;
    logic [XLEN-1:0] redirectAligned;
    logic [ILEN-1:0] headInstr;
    logic [XLEN-1:0] headPc;

    // Live requests (outstanding minus those already doomed) plus held
    // entries can never exceed DEPTH, so a kept response always finds room.
    assign credit = CW'(occCnt) + outstanding - dropCnt;

    assign imem_req_valid = !rst && !redirect_valid && (credit < CW'(DEPTH));
    assign imem_req_addr  = fetchPc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign rspOrphan = imem_rsp_valid && (outstanding == '0);
    assign rspAccept = imem_rsp_valid && (outstanding != '0);
    assign rspDrop   = rspAccept && (dropCnt != '0);
    // A response arriving in a redirect cycle belongs to the old path.
    assign pushEn    = rspAccept && (dropCnt == '0) && !redirect_valid;

    assign dec_valid = (occCnt != '0);
    assign popEn     = dec_valid && dec_ready && !redirect_valid;

    assign redirectAligned = redirect_pc & ~XLEN'(3);

    assign headInstr    = instrMem[rdPtr];
    assign headPc       = pcMem[rdPtr];
    assign dec_instr    = dec_valid ? headInstr : '0;
    assign dec_pc       = dec_valid ? headPc : '0;
    assign dec_pc_plus4 = dec_valid ? (headPc + XLEN'(4)) : '0;
    assign occupancy    = occCnt;
    assign protocol_err = protocolErr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            wrPtr       <= '0;
            rdPtr       <= '0;
            occCnt      <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
            protocolErr <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetchPc <= redirectAligned;
                rspPc   <= redirectAligned;
                wrPtr   <= '0;
                rdPtr   <= '0;
                occCnt  <= '0;
                // Everything still in flight after this edge is stale;
                // a response consumed this cycle is already accounted for.
                dropCnt <= outstanding - CW'(rspAccept);
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + XLEN'(4);
                end
                if (pushEn) begin
                    rspPc <= rspPc + XLEN'(4);
                    wrPtr <= wrPtr + PW'(1);
                end
                if (rspDrop) begin
                    dropCnt <= dropCnt - CW'(1);
                end
                if (popEn) begin
                    rdPtr <= rdPtr + PW'(1);
                end
                occCnt <= occCnt + OW'(pushEn) - OW'(popEn);
            end

            outstanding <= outstanding + CW'(reqFire) - CW'(rspAccept);

            if (rspOrphan) begin
                protocolErr <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            instrMem[wrPtr] <= imem_rsp_data;
            pcMem[wrPtr]    <= rspPc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- scoreboard bench for fetch_queue.
//
// The main process drives requests/redirects/reset from directed vectors
// and pushes the expected decode entries into expQ. A responder process
// models the imem with a programmable latency, and a monitor process pops
// expQ and compares whenever decode takes an entry.
//
// Timing within one clock period: main drives at the falling edge, checks
// combinational/registered outputs 1 time unit later, the responder acts
// at +2 and the monitor at +3; the DUT updates on the rising edge.

module tb_fetch_queue;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [ILEN-1:0] imem_rsp_data = '0;
    logic            dec_valid;
    logic            dec_ready = 1'b0;
    logic [ILEN-1:0] dec_instr;
    logic [XLEN-1:0] dec_pc;
    logic [XLEN-1:0] dec_pc_plus4;
    logic [2:0]      occupancy;
    logic            protocol_err;

    fetch_queue #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_instr(dec_instr),
        .dec_pc(dec_pc),
        .dec_pc_plus4(dec_pc_plus4),
        .occupancy(occupancy),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } exp_t;
    exp_t expQ[$];

    typedef struct packed {
        int              due;
        logic [ILEN-1:0] data;
    } rsp_t;
    rsp_t pendQ[$];

    int   cycIdx   = 0;
    int   lastDue  = -1;
    int   rspLat   = 1;
    logic forceRsp = 1'b0;

    // Instruction word the imem model returns for a given address.
    function automatic logic [ILEN-1:0] instrOf(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_pc(input logic [XLEN-1:0] pc);
        expQ.push_back('{pc: pc, instr: instrOf(pc)});
    endtask

    task automatic resetDut();
        tick();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        dec_ready = 1'b0;
        redirect_valid = 1'b0;
        forceRsp = 1'b0;
        #1;
        check("rst_occupancy", occupancy, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_dec_pc", dec_pc, 0);
        check("rst_protocol_err", protocol_err, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rel_req_valid", imem_req_valid, 1);
        check("rel_req_addr", imem_req_addr, RESET_PC);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        imem_req_ready = 1'b0;
        while ((expQ.size() != 0 || pendQ.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        nCompared++;
        if (expQ.size() != 0 || pendQ.size() != 0) begin
            nMismatched++;
            $display("FAIL drain_timeout: got %0d expected / %0d pending after %0d cycles, required 0",
                     expQ.size(), pendQ.size(), budget);
        end
    endtask

    // imem model: in-order responses rspLat edges after acceptance.
    initial begin
        int d;
        forever begin
            @(negedge clk);
            cycIdx++;
            #2;
            if (imem_req_valid && imem_req_ready) begin
                d = cycIdx + rspLat;
                if (d <= lastDue) d = lastDue + 1;
                lastDue = d;
                pendQ.push_back('{due: d, data: instrOf(imem_req_addr)});
            end
            if (pendQ.size() != 0 && pendQ[0].due <= cycIdx) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pendQ[0].data;
                void'(pendQ.pop_front());
            end else begin
                imem_rsp_valid = forceRsp;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: every entry decode takes must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && !redirect_valid && dec_valid && dec_ready) begin
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("FAIL unexpected_pop: got pc %h instr %h, required no entry", dec_pc, dec_instr);
                end else begin
                    e = expQ.pop_front();
                    $display("pop pc=%h instr=%h", dec_pc, dec_instr);
                    check("dec_pc", dec_pc, e.pc);
                    check("dec_instr", XLEN'(dec_instr), XLEN'(e.instr));
                    check("dec_pc_plus4", dec_pc_plus4, e.pc + 64'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: streaming, 1-cycle imem, decode always ready.
        resetDut();
        rspLat = 1;
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            imem_req_ready = 1'b1;
            #1;
            check("t1_req_valid", imem_req_valid, 1);
            check("t1_req_addr", imem_req_addr, 64'(i * 4));
            if (i == 1) check("t1_dec_valid_early", dec_valid, 0);
            if (i == 2) begin
                check("t1_dec_valid_first", dec_valid, 1);
                check("t1_dec_pc_first", dec_pc, 0);
            end
            expect_pc(64'(i * 4));
        end
        tick();
        waitDrain(20);

        // Test 2: decode stalled, credits run out after DEPTH requests.
        resetDut();
        rspLat = 1;
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            imem_req_ready = 1'b1;
            #1;
            check("t2_req_valid", imem_req_valid, 1);
            check("t2_req_addr", imem_req_addr, 64'(i * 4));
        end
        tick();
        #1;
        check("t2_req_valid_full", imem_req_valid, 0);
        tick();
        #1;
        check("t2_req_valid_held", imem_req_valid, 0);
        check("t2_occupancy_full", occupancy, 4);
        tick();
        imem_req_ready = 1'b0;
        dec_ready = 1'b1;
        expect_pc(64'h0);
        expect_pc(64'h4);
        expect_pc(64'h8);
        expect_pc(64'hC);
        #1;
        check("t2_req_valid_prepop", imem_req_valid, 0);
        tick();
        #1;
        check("t2_occupancy_after_pop", occupancy, 3);
        check("t2_req_valid_resume", imem_req_valid, 1);
        check("t2_req_addr_resume", imem_req_addr, 64'h10);
        waitDrain(20);

        // Test 3: redirect with two requests in flight.
        resetDut();
        rspLat = 3;
        dec_ready = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        #1;
        check("t3_req_addr0", imem_req_addr, 64'h0);
        tick();
        #1;
        check("t3_req_addr1", imem_req_addr, 64'h4);
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h103;
        #1;
        check("t3_req_valid_redirect", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("t3_req_valid_after", imem_req_valid, 1);
        check("t3_req_addr_after", imem_req_addr, 64'h100);
        expect_pc(64'h100);
        tick();
        #1;
        check("t3_req_addr_next", imem_req_addr, 64'h104);
        expect_pc(64'h104);
        tick();
        #1;
        check("t3_occ_after_drop", occupancy, 0);
        waitDrain(20);

        // Test 4: redirect coinciding with a response and req_ready.
        resetDut();
        rspLat = 2;
        dec_ready = 1'b1;
        tick();
        imem_req_ready = 1'b1;
        #1;
        check("t4_req_addr0", imem_req_addr, 64'h0);
        tick();
        imem_req_ready = 1'b0;
        tick();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        #1;
        check("t4_req_valid_redirect", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("t4_occupancy", occupancy, 0);
        check("t4_dec_valid", dec_valid, 0);
        check("t4_req_valid_after", imem_req_valid, 1);
        check("t4_req_addr_after", imem_req_addr, 64'h200);
        expect_pc(64'h200);
        tick();
        waitDrain(20);

        // Test 5: response with nothing outstanding, FIFO holding two entries.
        rspLat = 1;
        dec_ready = 1'b0;
        tick();
        imem_req_ready = 1'b1;
        #1;
        check("t5_req_addr0", imem_req_addr, 64'h204);
        tick();
        #1;
        check("t5_req_addr1", imem_req_addr, 64'h208);
        tick();
        imem_req_ready = 1'b0;
        tick();
        forceRsp = 1'b1;
        #1;
        check("t5_occ_before", occupancy, 2);
        check("t5_perr_before", protocol_err, 0);
        tick();
        forceRsp = 1'b0;
        #1;
        check("t5_perr_set", protocol_err, 1);
        check("t5_occ_unchanged", occupancy, 2);
        check("t5_req_addr_unchanged", imem_req_addr, 64'h20C);
        check("t5_dec_pc_unchanged", dec_pc, 64'h204);
        expect_pc(64'h204);
        expect_pc(64'h208);
        dec_ready = 1'b1;
        waitDrain(20);
        tick();
        #1;
        check("t5_perr_sticky", protocol_err, 1);

        // Test 6: reset mid-stream with entries held and requests in flight.
        resetDut();
        rspLat = 3;
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            imem_req_ready = 1'b1;
            #1;
            check("t6_req_addr", imem_req_addr, 64'(i * 4));
        end
        tick();
        imem_req_ready = 1'b0;
        tick();
        #1;
        check("t6_occ_before_rst", occupancy, 2);
        rst = 1'b1;
        #1;
        check("t6_rst_dec_valid", dec_valid, 0);
        check("t6_rst_occupancy", occupancy, 0);
        check("t6_rst_req_valid", imem_req_valid, 0);
        check("t6_rst_dec_pc", dec_pc, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_rel_req_valid", imem_req_valid, 1);
        check("t6_rel_req_addr", imem_req_addr, RESET_PC);
        check("t6_rel_perr", protocol_err, 0);
        tick();
        #1;
        check("t6_late_rsp_perr", protocol_err, 1);
        check("t6_late_rsp_occ", occupancy, 0);
        waitDrain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
